// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming(7,4) position map, frame states and encoder
package hamming_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int P4 = 3;
  function automatic logic [6:0] hamming74_encode(input logic [3:0] d);
    logic [6:0] c;
    c = {d[3], d[2], d[1], 1'b0, d[0], 2'b00};
    c[P1] = d[0] ^ d[1] ^ d[3];
    c[P2] = d[0] ^ d[2] ^ d[3];
    c[P4] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction
endpackage

// File: rtl/hamming_tx_baud_gen.sv
// baud_gen: enabled bit-period counter with a one-cycle tick on its last count
module baud_gen #(
  parameter int DIV = 2812
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  assign tick = en && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/hamming_tx.sv
// hamming_tx: Hamming(7,4) encoder with error injection and start/data/stop serial transmitter
module hamming_tx
  import hamming_pkg::*;
#(
  parameter int CLK_HZ   = 27_000_000,
  parameter int BAUD     = 9600,
  parameter int BAUD_DIV = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i,
  input  logic [2:0] err_pos,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [6:0] cw_out
);
  if (BAUD_DIV < 2) begin : g_div_chk
    $error("hamming_tx: BAUD_DIV must be >= 2");
  end
  state_t     state;
  logic [6:0] cw;
  logic [6:0] sh;
  logic [2:0] bit_cnt;
  logic       tick;
  assign cw = hamming74_encode(i) ^ (err_pos == 3'd0 ? 7'd0 : 7'd1 << (err_pos - 3'd1));
  baud_gen #(.DIV(BAUD_DIV)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state != IDLE),
    .tick (tick)
  );
  // sh is a private copy shifted out LSB first so cw_out stays stable for the whole frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      cw_out   <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (in_valid && in_ready) begin
          state    <= START;
          tx       <= 1'b0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          cw_out   <= cw;
          sh       <= cw;
        end
        START: if (tick) begin
          state   <= DATA;
          tx      <= sh[0];
          sh      <= sh >> 1;
          bit_cnt <= '0;
        end
        DATA: if (tick) begin
          if (bit_cnt == 3'd6) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            tx      <= sh[0];
            sh      <= sh >> 1;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        STOP: if (tick) begin
          state    <= IDLE;
          done     <= 1'b1;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_hamming_tx.sv
// tb_hamming_tx: scoreboard bench for hamming_tx with a textbook Hamming(7,4) reference model
module tb_hamming_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] i = '0;
  logic [2:0] err_pos = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy, done;
  logic [6:0] cw_out;
  int checks = 0;
  int failures = 0;
  logic [6:0] exp_q[$];

  hamming_tx #(.BAUD_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i),
    .err_pos (err_pos),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done),
    .cw_out  (cw_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (timeout or unexpected event)", name);
  endtask

  // positions 1..7; data fills non-powers-of-two in order, parity p covers positions with bit p set
  function automatic logic [6:0] model_cw(input logic [3:0] d, input logic [2:0] e);
    logic [6:0] c;
    int j;
    c = '0;
    j = 0;
    for (int k = 1; k <= 7; k++)
      if ((k & (k - 1)) != 0) begin
        c[k-1] = d[j];
        j++;
      end
    for (int p = 1; p <= 4; p = p * 2)
      for (int k = 1; k <= 7; k++)
        if (k != p && (k & p) != 0) c[p-1] = c[p-1] ^ c[k-1];
    if (e != 0) c[e-1] = ~c[e-1];
    return c;
  endfunction

  initial begin : mon
    logic [8:0] got;
    logic [6:0] e;
    logic ok_busy, early, abort;
    forever begin
      @(negedge clk);
      if (rst_n && !tx) begin
        if (exp_q.size() == 0) fail("unexpected_frame");
        else begin
          e = exp_q.pop_front();
          got = '0;
          check("cw_at_start", 32'(cw_out), 32'(e));
          ok_busy = busy && !in_ready;
          early = 1'b0;
          abort = 1'b0;
          for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (!rst_n) begin
              abort = 1'b1;
              break;
            end
            if (n % 4 == 2) got[n/4] = tx;
            if (n < 36) begin
              ok_busy = ok_busy & busy & ~in_ready;
              early = early | done;
            end
          end
          if (!abort) begin
            check("frame_bits", 32'(got), 32'({1'b1, e, 1'b0}));
            check("busy_not_ready", 32'(ok_busy), 32'd1);
            check("done_early", 32'(early), 32'd0);
            check("done_cycle", 32'({done, busy, in_ready, tx}), 32'b1011);
            check("cw_hold", 32'(cw_out), 32'(e));
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) fail("ready_timeout");
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) fail("done_timeout");
  endtask

  task automatic send(input logic [3:0] d, input logic [2:0] e);
    wait_ready();
    i = d;
    err_pos = e;
    in_valid = 1'b1;
    exp_q.push_back(model_cw(d, e));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (5) begin
      i = 4'($urandom);
      err_pos = 3'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      check("reset_state", 32'({tx, in_ready, busy, done, cw_out}), 32'b11000000000);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    send(4'b0101, 3'd0);
    wait_done();
    @(negedge clk);
    send(4'b0101, 3'd5);
    wait_done();
    @(negedge clk);
    wait_ready();
    i = 4'b1000;
    err_pos = 3'd0;
    in_valid = 1'b1;
    exp_q.push_back(model_cw(4'b1000, 3'd0));
    @(negedge clk);
    i = 4'b1111;
    exp_q.push_back(model_cw(4'b1111, 3'd0));
    wait_done();
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_start", 32'({tx, busy}), 32'b01);
    wait_done();
    @(negedge clk);
    send(4'b0011, 3'($urandom));
    repeat (25) begin
      i = 4'($urandom);
      err_pos = 3'($urandom);
      in_valid = 1'($urandom);
      check("ignore_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_done();
    @(negedge clk);
    repeat (8) begin
      send(4'($urandom), 3'($urandom));
      wait_done();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    send(4'b0110, 3'd0);
    repeat (17) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_async", 32'({tx, busy, in_ready}), 32'b101);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'b1111, 3'd0);
    wait_done();
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
